turing_machine_core: RTL and testbench

Parametrised single-tape Turing machine engine, the successor to the fixed-size switch-programmed machine. It holds a loadable transition table and a register-based tape, and runs either freely or one transition per `step` pulse. It reports state, head position, step count, halt and bounds-error status. It sits behind the FPGA/chip I/O wrapper, which handles debouncing, display muxing and button/switch mapping.

---
 rtl/turing_machine_core.sv | 158 +++++++++++++++
 tb/tb_turing_machine_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/turing_machine_core.sv
// turing_machine_core: single-tape Turing machine engine with loadable table and register tape.
// Latency: 2 cycles per transition (FETCH then EXEC); free-run or one transition per step pulse.
// Backpressure: none; host table/tape writes are dropped while busy. Optional macro: TM_TIMEOUT_EN.
module turing_machine_core #(
    parameter  int NUM_STATES = 4,
    parameter  int SYM_BITS   = 2,
    parameter  int TAPE_LEN   = 16,
    parameter  int STEP_BITS  = 16,
    parameter  int MAX_STEPS  = 1000,
    localparam int STATE_BITS = $clog2(NUM_STATES),
    localparam int HEAD_BITS  = $clog2(TAPE_LEN),
    localparam int ADDR_W     = STATE_BITS + SYM_BITS,
    localparam int ENT_W      = ADDR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [ENT_W-1:0]      prog_data,
    input  logic                  tape_we,
    input  logic [HEAD_BITS-1:0]  tape_addr,
    input  logic [SYM_BITS-1:0]   tape_wdata,
    output logic [SYM_BITS-1:0]   tape_rdata,
    input  logic [HEAD_BITS-1:0]  head_init,
    input  logic                  start,
    input  logic                  step_mode,
    input  logic                  step,
    output logic                  busy,
    output logic                  halted,
    output logic                  err_bounds,
    output logic                  timeout,
    output logic [STATE_BITS-1:0] cur_state,
    output logic [HEAD_BITS-1:0]  head_pos,
    output logic [STEP_BITS-1:0]  step_count
);

    localparam int                  TBL_DEPTH  = 1 << ADDR_W;
    localparam logic [STATE_BITS-1:0] HALT_STATE = STATE_BITS'(NUM_STATES - 1);
    localparam logic [HEAD_BITS-1:0]  HEAD_MAX   = HEAD_BITS'(TAPE_LEN - 1);

    // The watchdog limit must be reachable by the saturating counter.
    if (MAX_STEPS < 1 || MAX_STEPS > (2 ** STEP_BITS) - 1) begin : g_bad_max_steps
        $error("MAX_STEPS does not fit in STEP_BITS");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_PAUSE, S_HALT, S_ERROR
    } fsm_t;

    fsm_t                  state_q;
    logic [ENT_W-1:0]      table_q [TBL_DEPTH];
    logic [SYM_BITS-1:0]   tape_q  [TAPE_LEN];
    logic [ENT_W-1:0]      entry_q;
    logic [STATE_BITS-1:0] cur_state_q;
    logic [HEAD_BITS-1:0]  head_q;
    logic [STEP_BITS-1:0]  step_q;

    logic                  busy_w;
    logic [SYM_BITS-1:0]   rd_sym;
    logic [STATE_BITS-1:0] ent_next_raw;
    logic [STATE_BITS-1:0] ent_next;
    logic [SYM_BITS-1:0]   ent_wsym;
    logic                  ent_move;
    logic                  at_edge;
    logic                  go_halt;
    logic [STEP_BITS-1:0]  step_d;

    assign busy_w       = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_PAUSE);
    assign rd_sym       = tape_q[head_q];
    assign ent_next_raw = entry_q[ENT_W-1 -: STATE_BITS];
    assign ent_wsym     = entry_q[SYM_BITS:1];
    assign ent_move     = entry_q[0];

    // Unreachable state encodings only exist when NUM_STATES is not a power of two; fold them into halt.
    if (NUM_STATES == (1 << STATE_BITS)) begin : g_next_pow2
        assign ent_next = ent_next_raw;
    end else begin : g_next_clamp
        assign ent_next = (ent_next_raw >= STATE_BITS'(NUM_STATES)) ? HALT_STATE : ent_next_raw;
    end

    assign at_edge = ent_move ? (head_q == HEAD_MAX) : (head_q == '0);
    assign go_halt = (ent_next == HALT_STATE);
    assign step_d  = (&step_q) ? step_q : step_q + 1'b1;

`ifdef TM_TIMEOUT_EN
    logic timeout_q;
    logic go_tmo;
    assign go_tmo  = (step_d == STEP_BITS'(MAX_STEPS));
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Control FSM plus table, tape and machine registers; host writes only land while not busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            entry_q     <= '0;
            cur_state_q <= '0;
            head_q      <= '0;
            step_q      <= '0;
            for (int i = 0; i < TBL_DEPTH; i++) table_q[i] <= '0;
            for (int i = 0; i < TAPE_LEN; i++)  tape_q[i]  <= '0;
`ifdef TM_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            if (!busy_w && prog_we) table_q[prog_addr] <= prog_data;
            if (!busy_w && tape_we) tape_q[tape_addr]  <= tape_wdata;
            case (state_q)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        cur_state_q <= '0;
                        head_q      <= head_init;
                        step_q      <= '0;
`ifdef TM_TIMEOUT_EN
                        timeout_q   <= 1'b0;
`endif
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    entry_q <= table_q[{cur_state_q, rd_sym}];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    tape_q[head_q] <= ent_wsym;
                    cur_state_q    <= ent_next;
                    step_q         <= step_d;
                    if (!at_edge) head_q <= ent_move ? head_q + 1'b1 : head_q - 1'b1;
                    if (at_edge)        state_q <= S_ERROR;
                    else if (go_halt)   state_q <= S_HALT;
`ifdef TM_TIMEOUT_EN
                    else if (go_tmo) begin
                        state_q   <= S_HALT;
                        timeout_q <= 1'b1;
                    end
`endif
                    else if (step_mode) state_q <= S_PAUSE;
                    else                state_q <= S_FETCH;
                end
                S_PAUSE: begin
                    if (step || !step_mode) state_q <= S_FETCH;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_w;
    assign halted     = (state_q == S_HALT);
    assign err_bounds = (state_q == S_ERROR);
    assign cur_state  = cur_state_q;
    assign head_pos   = head_q;
    assign step_count = step_q;
    assign tape_rdata = tape_q[tape_addr];

endmodule

// File: tb/tb_turing_machine_core.sv
// Bench for turing_machine_core: directed runs; a monitor checks the final machine
// status against a queue of expected results each time busy falls.
module tb_turing_machine_core;

`ifdef TM_TIMEOUT_EN
    localparam int MAXS = 5;
`else
    localparam int MAXS = 1000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [4:0]  prog_data;
    logic        tape_we;
    logic [3:0]  tape_addr;
    logic [1:0]  tape_wdata;
    logic [1:0]  tape_rdata;
    logic [3:0]  head_init;
    logic        start, step_mode, step;
    logic        busy, halted, err_bounds, timeout;
    logic [1:0]  cur_state;
    logic [3:0]  head_pos;
    logic [15:0] step_count;

    turing_machine_core #(.MAX_STEPS(MAXS)) dut (
        .clock(clock), .reset(reset),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata), .tape_rdata(tape_rdata),
        .head_init(head_init), .start(start), .step_mode(step_mode), .step(step),
        .busy(busy), .halted(halted), .err_bounds(err_bounds), .timeout(timeout),
        .cur_state(cur_state), .head_pos(head_pos), .step_count(step_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        h;
        logic        e;
        logic        t;
        logic [1:0]  st;
        logic [3:0]  hd;
        logic [15:0] sc;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic prog(input logic [3:0] a, input logic [4:0] d);
        prog_addr = a; prog_data = d; prog_we = 1'b1;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic tape_wr(input logic [3:0] a, input logic [1:0] d);
        tape_addr = a; tape_wdata = d; tape_we = 1'b1;
        tick();
        tape_we = 1'b0;
    endtask

    task automatic tape_chk(input logic [3:0] a, input logic [1:0] d);
        tape_addr = a;
        #1;
        chk($sformatf("tape[%0d]", a), 32'(tape_rdata), 32'(d));
    endtask

    task automatic start_run(input logic [3:0] h, input logic mode);
        head_init = h; step_mode = mode; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
    endtask

    task automatic push(input logic h, e, t, input logic [1:0] st, input logic [3:0] hd,
                        input logic [15:0] sc);
        rec_t r;
        r = '{h: h, e: e, t: t, st: st, hd: hd, sc: sc};
        exp_q.push_back(r);
    endtask

    // Monitor: whenever a run ends (busy falls), compare the status against the next expected record.
    initial begin
        logic prev_busy;
        rec_t r;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL monitor: run ended with no expected record");
                end else begin
                    r = exp_q.pop_front();
                    chk("mon.halted",     32'(halted),     32'(r.h));
                    chk("mon.err_bounds", 32'(err_bounds), 32'(r.e));
                    chk("mon.timeout",    32'(timeout),    32'(r.t));
                    chk("mon.cur_state",  32'(cur_state),  32'(r.st));
                    chk("mon.head_pos",   32'(head_pos),   32'(r.hd));
                    chk("mon.step_count", 32'(step_count), 32'(r.sc));
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; prog_we = 0; prog_addr = 0; prog_data = 0; tape_we = 0; tape_addr = 0;
        tape_wdata = 0; head_init = 0; start = 0; step_mode = 0; step = 0;
        repeat (2) tick();
        chk("rst.busy", 32'(busy), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.err", 32'(err_bounds), 0);
        chk("rst.timeout", 32'(timeout), 0);
        chk("rst.state", 32'(cur_state), 0);
        chk("rst.head", 32'(head_pos), 0);
        chk("rst.count", 32'(step_count), 0);
        reset = 1'b0;
        tick();

        // Binary incrementer, free-run: halt visible two edges after the 3rd transition begins.
        prog(4'd1, 5'b00001);
        prog(4'd0, 5'b11011);
        tape_wr(0, 1); tape_wr(1, 1); tape_wr(2, 0);
        push(1, 0, 0, 3, 3, 3);
        start_run(0, 0);
        repeat (4) tick();
        chk("inc.halted_t5", 32'(halted), 0);
        repeat (2) tick();
        chk("inc.halted_t7", 32'(halted), 1);
        tape_chk(0, 0); tape_chk(1, 0); tape_chk(2, 1);

        // Same program, single-step; a start pulse in PAUSE must be ignored.
        tape_wr(0, 1); tape_wr(1, 1); tape_wr(2, 0);
        push(1, 0, 0, 3, 3, 3);
        start_run(0, 1);
        repeat (2) tick();
        chk("ss.count1", 32'(step_count), 1);
        repeat (3) tick();
        chk("ss.count1_hold", 32'(step_count), 1);
        chk("ss.busy_pause", 32'(busy), 1);
        head_init = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("ss.start_ign_count", 32'(step_count), 1);
        chk("ss.start_ign_head", 32'(head_pos), 1);
        step = 1'b1; tick(); step = 1'b0;
        repeat (2) tick();
        chk("ss.count2", 32'(step_count), 2);
        chk("ss.head2", 32'(head_pos), 2);
        step = 1'b1; tick(); step = 1'b0;
        repeat (2) tick();
        chk("ss.halted", 32'(halted), 1);
        step_mode = 1'b0;

        // Bounds error moving left at head 0.
        prog(4'd0, 5'b01100);
        push(0, 1, 0, 1, 0, 1);
        start_run(0, 0);
        wait_idle(20);
        chk("bl.err", 32'(err_bounds), 1);
        tape_chk(0, 2);

        // Bounds error moving right at the last cell.
        prog(4'd0, 5'b01101);
        push(0, 1, 0, 1, 15, 1);
        start_run(15, 0);
        wait_idle(20);
        chk("br.err", 32'(err_bounds), 1);
        tape_chk(15, 2);

        // Self-loop moving right, with table/tape writes attempted while busy.
        prog(4'd0, 5'b00001);
        for (int i = 0; i < 16; i++) tape_wr(4'(i), 0);
`ifdef TM_TIMEOUT_EN
        push(1, 0, 1, 0, 5, 5);
`else
        push(0, 1, 0, 0, 15, 16);
`endif
        start_run(0, 0);
        tick();
        prog_addr = 4'd0; prog_data = 5'b11011; prog_we = 1'b1;
        tape_addr = 4'd0; tape_wdata = 2'd3; tape_we = 1'b1;
        repeat (4) tick();
        prog_we = 1'b0; tape_we = 1'b0;
        wait_idle(100);
        tape_chk(0, 0);

        // Restart with freshly loaded state after the previous run ended.
        prog(4'd0, 5'b11011);
        tape_wr(0, 1); tape_wr(1, 1); tape_wr(2, 0);
        push(1, 0, 0, 3, 3, 3);
        start_run(0, 0);
        chk("rs.count0", 32'(step_count), 0);
        chk("rs.busy", 32'(busy), 1);
        chk("rs.flags", 32'({halted, err_bounds, timeout}), 0);
        wait_idle(20);
        tape_chk(2, 1);

        // Asynchronous reset in the middle of a run.
        tape_wr(0, 1); tape_wr(1, 1); tape_wr(2, 0);
        start_run(0, 0);
        repeat (2) tick();
        push(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("ar.busy", 32'(busy), 0);
        chk("ar.count", 32'(step_count), 0);
        chk("ar.head", 32'(head_pos), 0);
        for (int i = 0; i < 4; i++) tape_chk(4'(i), 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: %0d expected results never observed", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
